i2c_burst_master: RTL and testbench
===================================

I2C_BURST_MASTER -- requirements
Module: i2c_burst_master

Interface
REQ-001 SHALL have parameter CLK_DIV, default 125: clk cycles per SCL quarter-period; legal range >=1.
REQ-002 SHALL have parameter MAX_BYTES, default 4: maximum data bytes per transaction; legal range >=1.
REQ-003 SHALL have parameter LEN_W, default $clog2(MAX_BYTES+1): width of length.
REQ-004 SHALL have one clock, clk; reset is synchronous and active-high, named reset.
REQ-005 Ports: clk in 1 system clock; reset in 1 sync active-high reset.
REQ-006 Ports: start in 1 (request pulse); rw in 1 (0=write, 1=read); periph_addr in 7 (target address); length in LEN_W (data byte count).
REQ-007 Ports: tx_data in 8 (write byte); tx_ready out 1 (pulse: tx_data consumed this cycle).
REQ-008 Ports: rx_data out 8 (received byte); rx_valid out 1 (pulse: rx_data valid).
REQ-009 Ports: busy out 1; done out 1 (end-of-transaction pulse); nack out 1 (sticky NACK flag).
REQ-010 Ports: scl out 1; sda_oe out 1 (1 = pull SDA low); sda_in in 1 (sampled bus SDA); state out 4 (debug state code).

Function
REQ-011 Timing SHALL come from a divider: a quarter-tick occurs every CLK_DIV clk cycles; a bit cell is quarters Q0..Q3.
- Data cells: SCL low in Q0–Q1 and high in Q2–Q3; SDA changes only at Q0 entry; SDA is sampled at Q3 entry.
REQ-012 FSM states and codes SHALL be IDLE=0, START=1, ADDR=2, ADDR_ACK=3, WR_BYTE=4, WR_ACK=5, RD_BYTE=6, RD_ACK=7, STOP=8; state port reflects the current state.
REQ-013 In IDLE, a sampled start=1 SHALL latch rw, periph_addr and length, clear the divider and nack, and enter START; busy goes high the next cycle.
REQ-014 START (one cell) SHALL hold SCL high throughout, release SDA in Q0–Q1 and pull it low in Q2–Q3.
REQ-015 ADDR SHALL shift out {periph_addr, rw} MSB-first over 8 cells; ADDR_ACK SHALL release SDA for one cell and sample it.
REQ-016 After an ACK (SDA=0) the FSM SHALL go to WR_BYTE (rw=0) or RD_BYTE (rw=1); a remaining count of 0 goes to STOP.
REQ-017 On entry to WR_BYTE, tx_ready SHALL pulse for exactly one clk cycle, and tx_data SHALL be loaded in that cycle.
- Each byte is sent MSB-first over 8 cells; WR_ACK then samples the slave ACK.
REQ-018 After each byte the remaining count SHALL decrement; WR_ACK goes to WR_BYTE while count>0, otherwise to STOP.
REQ-019 RD_BYTE SHALL release SDA and sample 8 bits MSB-first; rx_valid SHALL pulse one cycle at entry to RD_ACK with the assembled rx_data.
- rx_data holds its value until the next byte is received.
REQ-020 RD_ACK SHALL drive ACK (sda_oe=1) when bytes remain and NACK (sda_oe=0) after the last byte.
REQ-021 A NACK in ADDR_ACK or WR_ACK SHALL set nack=1 and go directly to STOP, with no further tx_ready.
REQ-022 STOP (one cell) SHALL drive SCL low/SDA low in Q0, SCL high/SDA low in Q1, and SCL high/SDA released in Q2–Q3.
REQ-023 At the end of STOP, done SHALL pulse one cycle, busy SHALL drop in that same cycle, and the FSM SHALL enter IDLE.
REQ-024 start SHALL be ignored while busy=1.
REQ-025 length>MAX_BYTES SHALL be clamped to MAX_BYTES; length=0 SHALL perform an address-only probe (START, ADDR, ADDR_ACK, STOP).
REQ-026 Transaction duration SHALL be (2 + 9*(1+N))*4*CLK_DIV clk cycles from the first cycle after start acceptance to done, where N is the effective byte count.
- If a NACK occurs, N counts only the bytes sent before the NACK.
REQ-027 nack SHALL remain set until the next accepted start or reset.

Reset
REQ-028 With reset=1 at a clk edge, outputs SHALL be: state=IDLE, scl=1, sda_oe=0, busy=0, done=0, nack=0, tx_ready=0, rx_valid=0, rx_data=0; the divider and counters are cleared.
REQ-029 A reset during a transaction SHALL abort at the next edge and release the bus immediately, without generating a STOP.

Verification
REQ-030 CLK_DIV=2, write, addr=0x04, length=1, tx_data=0xE6, slave ACKs -> SDA bits 0x08 then 0xE6.
- Exactly one tx_ready; done at cycle 160; nack=0.
REQ-031 CLK_DIV=2, read, addr=0x04, length=2, slave returns 0xA5, 0x3C -> two rx_valid pulses with rx_data=0xA5 then 0x3C.
- Master ACKs the first byte and NACKs the second; done at cycle 232.
REQ-032 Write length=3 with the slave NACKing the address -> nack=1, zero tx_ready, STOP issued, done at cycle 88.
REQ-033 length=0 probe with ACK -> done at cycle 88, nack=0; length=7 with MAX_BYTES=4 -> exactly 4 tx_ready pulses.
REQ-034 Reset asserted mid-WR_BYTE -> next cycle scl=1, sda_oe=0, busy=0, state=0; a start pulse during busy produces no second transaction.

Source files
------------

// File: rtl/i2c_burst_master.sv
// I2C burst master: START, 7-bit address + R/W, up to MAX_BYTES data bytes, STOP.
// Each bit cell is four quarter-periods of CLK_DIV clocks; SCL/SDA are decoded from the cell phase.
module i2c_burst_master #(
  parameter int CLK_DIV   = 125,
  parameter int MAX_BYTES = 4,
  parameter int LEN_W     = $clog2(MAX_BYTES + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             rw,
  input  logic [6:0]       periph_addr,
  input  logic [LEN_W-1:0] length,
  input  logic [7:0]       tx_data,
  output logic             tx_ready,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  output logic             busy,
  output logic             done,
  output logic             nack,
  output logic             scl,
  output logic             sda_oe,
  input  logic             sda_in,
  output logic [3:0]       state
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_BYTES);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_START    = 4'd1,
    S_ADDR     = 4'd2,
    S_ADDR_ACK = 4'd3,
    S_WR_BYTE  = 4'd4,
    S_WR_ACK   = 4'd5,
    S_RD_BYTE  = 4'd6,
    S_RD_ACK   = 4'd7,
    S_STOP     = 4'd8
  } state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q;
  logic [1:0]       qtr_q;
  logic [2:0]       bit_q;
  logic [7:0]       shreg_q;
  logic [7:0]       rx_sh_q;
  logic [7:0]       rx_data_q;
  logic [LEN_W-1:0] cnt_q;
  logic             rw_q;
  logic [6:0]       addr_q;
  logic             ack_q;      // sampled SDA level: 1 means the slave did not acknowledge
  logic             nack_q;
  logic             done_q;
  logic             rx_valid_q;

  logic             tick;
  logic             cell_end;
  logic             sample_pt;
  logic             last_bit;
  logic             shifting;
  logic             tx_load;
  logic             tx_bit;
  logic [LEN_W-1:0] len_eff;

  assign tick      = (div_q == DIV_LAST);
  assign cell_end  = tick && (qtr_q == 2'd3);
  assign sample_pt = tick && (qtr_q == 2'd2);
  assign last_bit  = (bit_q == 3'd7);
  assign shifting  = (state_q == S_ADDR) || (state_q == S_WR_BYTE) || (state_q == S_RD_BYTE);
  assign len_eff   = (length > LEN_MAX) ? LEN_MAX : length;

  // The byte is loaded on the first cycle of WR_BYTE, so its MSB is taken straight from tx_data then.
  assign tx_load = (state_q == S_WR_BYTE) && (bit_q == 3'd0) && (qtr_q == 2'd0) && (div_q == '0);
  assign tx_bit  = tx_load ? tx_data[7] : shreg_q[7];

  // NOTE: every variable gets a default first, so no path through the block can infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (start) state_d = S_START;
      S_START:    if (cell_end) state_d = S_ADDR;
      S_ADDR:     if (cell_end && last_bit) state_d = S_ADDR_ACK;
      S_ADDR_ACK: if (cell_end) begin
                    if (ack_q || (cnt_q == '0)) state_d = S_STOP;
                    else if (rw_q)              state_d = S_RD_BYTE;
                    else                        state_d = S_WR_BYTE;
                  end
      S_WR_BYTE:  if (cell_end && last_bit) state_d = S_WR_ACK;
      S_WR_ACK:   if (cell_end) state_d = (ack_q || (cnt_q == '0)) ? S_STOP : S_WR_BYTE;
      S_RD_BYTE:  if (cell_end && last_bit) state_d = S_RD_ACK;
      S_RD_ACK:   if (cell_end) state_d = (cnt_q == '0) ? S_STOP : S_RD_BYTE;
      S_STOP:     if (cell_end) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_comb begin
    scl    = 1'b1;
    sda_oe = 1'b0;
    case (state_q)
      S_START:    sda_oe = qtr_q[1];
      S_ADDR:     begin scl = qtr_q[1]; sda_oe = ~shreg_q[7]; end
      S_WR_BYTE:  begin scl = qtr_q[1]; sda_oe = ~tx_bit; end
      S_ADDR_ACK,
      S_WR_ACK,
      S_RD_BYTE:  scl = qtr_q[1];
      S_RD_ACK:   begin scl = qtr_q[1]; sda_oe = (cnt_q != '0); end
      S_STOP:     begin scl = (qtr_q != 2'd0); sda_oe = (qtr_q < 2'd2); end
      default:    ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      div_q      <= '0;
      qtr_q      <= '0;
      bit_q      <= '0;
      shreg_q    <= '0;
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      cnt_q      <= '0;
      rw_q       <= 1'b0;
      addr_q     <= '0;
      ack_q      <= 1'b0;
      nack_q     <= 1'b0;
      done_q     <= 1'b0;
      rx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      done_q     <= (state_q == S_STOP) && cell_end;
      rx_valid_q <= (state_q == S_RD_BYTE) && cell_end && last_bit;

      if (state_q == S_IDLE) begin
        div_q <= '0;
        qtr_q <= '0;
        bit_q <= '0;
      end else if (tick) begin
        div_q <= '0;
        qtr_q <= qtr_q + 2'd1;
      end else begin
        div_q <= div_q + DIV_W'(1);
      end

      if ((state_q == S_IDLE) && start) begin
        rw_q   <= rw;
        addr_q <= periph_addr;
        cnt_q  <= len_eff;
        nack_q <= 1'b0;
      end

      if (sample_pt) begin
        ack_q <= sda_in;
        if (state_q == S_RD_BYTE) rx_sh_q <= {rx_sh_q[6:0], sda_in};
      end

      if (tx_load) shreg_q <= tx_data;

      if (cell_end) begin
        bit_q <= shifting ? bit_q + 3'd1 : 3'd0;
        if (state_q == S_START) shreg_q <= {addr_q, rw_q};
        if ((state_q == S_ADDR) || (state_q == S_WR_BYTE)) shreg_q <= {shreg_q[6:0], 1'b0};
        if (((state_q == S_WR_BYTE) || (state_q == S_RD_BYTE)) && last_bit) cnt_q <= cnt_q - LEN_W'(1);
        if ((state_q == S_RD_BYTE) && last_bit) rx_data_q <= rx_sh_q;
        if (((state_q == S_ADDR_ACK) || (state_q == S_WR_ACK)) && ack_q) nack_q <= 1'b1;
      end
    end
  end

  assign tx_ready = tx_load;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign nack     = nack_q;
  assign state    = state_q;

endmodule

// File: tb/tb_i2c_burst_master.sv
// Directed bench for i2c_burst_master: a table of transactions against a simple I2C slave model,
// plus hand-written reset-abort and start-while-busy sequences.
module tb_i2c_burst_master;

  localparam int CLK_DIV   = 2;
  localparam int MAX_BYTES = 4;
  localparam int LEN_W     = $clog2(MAX_BYTES + 1);

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             rw;
  logic [6:0]       periph_addr;
  logic [LEN_W-1:0] length;
  logic [7:0]       tx_data;
  logic             tx_ready;
  logic [7:0]       rx_data;
  logic             rx_valid;
  logic             busy;
  logic             done;
  logic             nack;
  logic             scl;
  logic             sda_oe;
  logic             sda_in;
  logic [3:0]       state;

  i2c_burst_master #(.CLK_DIV(CLK_DIV), .MAX_BYTES(MAX_BYTES)) dut (
    .clk(clk), .reset(reset), .start(start), .rw(rw), .periph_addr(periph_addr),
    .length(length), .tx_data(tx_data), .tx_ready(tx_ready), .rx_data(rx_data),
    .rx_valid(rx_valid), .busy(busy), .done(done), .nack(nack), .scl(scl),
    .sda_oe(sda_oe), .sda_in(sda_in), .state(state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Slave configuration for the current transaction
  logic       cfg_rw;
  logic       cfg_addr_ack;
  int         cfg_n;
  int         cfg_nack_byte;
  logic [7:0] cfg_rd [0:3];

  // Bus monitor and slave model, evaluated mid-cycle
  logic       pull = 1'b0;
  logic       prev_scl = 1'b1;
  int         rise_k = 0;
  int         rx_idx = 0;
  int         txr_cnt = 0;
  int         rxv_cnt = 0;
  int         done_cnt = 0;
  logic       bits [0:63];
  logic [7:0] rx_got [0:7];

  assign sda_in = ~(sda_oe | pull);

  always @(negedge clk) begin
    if (tx_ready) txr_cnt++;
    if (rx_valid) begin
      if (rx_idx < 8) rx_got[rx_idx] = rx_data;
      rx_idx++;
      rxv_cnt++;
    end
    if (done) done_cnt++;
    if (busy && scl && !prev_scl) begin
      int p, b, i;
      if (rise_k < 64) bits[rise_k] = ~sda_oe;
      pull = 1'b0;
      if (rise_k == 8) pull = cfg_addr_ack;
      else if (rise_k > 8) begin
        p = rise_k - 9;
        b = p / 9;
        i = p % 9;
        if (b < cfg_n) begin
          if (cfg_rw) pull = (i < 8) ? ~cfg_rd[b][7-i] : 1'b0;
          else        pull = (i == 8) ? (b != cfg_nack_byte) : 1'b0;
        end
      end
      rise_k++;
    end
    if (!busy) begin
      pull   = 1'b0;
      rise_k = 0;
      rx_idx = 0;
    end
    prev_scl = scl;
  end

  typedef struct packed {
    logic        rw;
    logic [6:0]  addr;
    logic [2:0]  len;
    logic        addr_ack;
    logic [3:0]  nack_byte;  // data byte index the slave NACKs; 15 = none
    logic [7:0]  tx;
    logic [7:0]  rd0;
    logic [7:0]  rd1;
    logic [15:0] exp_cycles;
    logic [3:0]  exp_txr;
    logic [3:0]  exp_rxv;
    logic        exp_nack;
  } vec_t;

  vec_t vecs [0:6];

  task automatic byte_at(input int base, output logic [7:0] val);
    for (int j = 0; j < 8; j++) val[7-j] = bits[base+j];
  endtask

  task automatic start_txn(input logic t_rw, input logic [6:0] t_addr, input logic [LEN_W-1:0] t_len,
                           input logic [7:0] t_tx);
    rw          = t_rw;
    periph_addr = t_addr;
    length      = t_len;
    tx_data     = t_tx;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    int   cycles;
    int   txr0, rxv0, dn0, n;
    logic got;
    logic [7:0] bv;
    vec_t v;

    vecs[0] = '{1'b0, 7'h04, 3'd1, 1'b1, 4'hF, 8'hE6, 8'h00, 8'h00, 16'd160, 4'd1, 4'd0, 1'b0};
    vecs[1] = '{1'b1, 7'h04, 3'd2, 1'b1, 4'hF, 8'h00, 8'hA5, 8'h3C, 16'd232, 4'd0, 4'd2, 1'b0};
    vecs[2] = '{1'b0, 7'h04, 3'd3, 1'b0, 4'hF, 8'h55, 8'h00, 8'h00, 16'd88,  4'd0, 4'd0, 1'b1};
    vecs[3] = '{1'b0, 7'h04, 3'd0, 1'b1, 4'hF, 8'h00, 8'h00, 8'h00, 16'd88,  4'd0, 4'd0, 1'b0};
    vecs[4] = '{1'b0, 7'h2A, 3'd7, 1'b1, 4'hF, 8'h81, 8'h00, 8'h00, 16'd376, 4'd4, 4'd0, 1'b0};
    vecs[5] = '{1'b1, 7'h51, 3'd1, 1'b1, 4'hF, 8'h00, 8'h5A, 8'h00, 16'd160, 4'd0, 4'd1, 1'b0};
    vecs[6] = '{1'b0, 7'h13, 3'd3, 1'b1, 4'd0, 8'h3C, 8'h00, 8'h00, 16'd160, 4'd1, 4'd0, 1'b1};

    reset = 1'b1; start = 1'b0; rw = 1'b0; periph_addr = '0; length = '0; tx_data = '0;
    cfg_rw = 1'b0; cfg_addr_ack = 1'b1; cfg_n = 0; cfg_nack_byte = 15;
    for (int j = 0; j < 4; j++) cfg_rd[j] = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_state", 32'(state), 32'd0);
    check("reset_scl", 32'(scl), 32'd1);
    check("reset_sda_oe", 32'(sda_oe), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_nack", 32'(nack), 32'd0);
    check("reset_tx_ready", 32'(tx_ready), 32'd0);
    check("reset_rx_valid", 32'(rx_valid), 32'd0);
    check("reset_rx_data", 32'(rx_data), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    for (int vi = 0; vi < 7; vi++) begin
      v = vecs[vi];
      n = (int'(v.len) > MAX_BYTES) ? MAX_BYTES : int'(v.len);
      cfg_rw = v.rw; cfg_addr_ack = v.addr_ack; cfg_n = n; cfg_nack_byte = int'(v.nack_byte);
      cfg_rd[0] = v.rd0; cfg_rd[1] = v.rd1;
      txr0 = txr_cnt; rxv0 = rxv_cnt;
      start_txn(v.rw, v.addr, v.len, v.tx);
      check($sformatf("v%0d_busy", vi), 32'(busy), 32'd1);
      cycles = 0; got = 1'b0;
      while (!got && cycles < 3000) begin
        @(posedge clk);
        cycles++;
        @(negedge clk);
        if (done) got = 1'b1;
      end
      check($sformatf("v%0d_done_cycle", vi), got ? 32'(cycles) : 32'hFFFF_FFFF, 32'(v.exp_cycles));
      check($sformatf("v%0d_busy_at_done", vi), 32'(busy), 32'd0);
      check($sformatf("v%0d_tx_ready_count", vi), 32'(txr_cnt - txr0), 32'(v.exp_txr));
      check($sformatf("v%0d_rx_valid_count", vi), 32'(rxv_cnt - rxv0), 32'(v.exp_rxv));
      byte_at(0, bv);
      check($sformatf("v%0d_addr_byte", vi), 32'(bv), 32'({v.addr, v.rw}));
      if (v.exp_txr != 0) begin
        byte_at(9, bv);
        check($sformatf("v%0d_wr_byte0", vi), 32'(bv), 32'(v.tx));
      end
      if (v.rw) begin
        for (int b = 0; b < int'(v.exp_rxv); b++) begin
          check($sformatf("v%0d_rx_byte%0d", vi, b), 32'(rx_got[b]), 32'(cfg_rd[b]));
          check($sformatf("v%0d_master_ack%0d", vi, b), 32'(bits[17 + 9*b]), (b < n - 1) ? 32'd0 : 32'd1);
        end
      end
      repeat (3) @(negedge clk);
      check($sformatf("v%0d_nack", vi), 32'(nack), 32'(v.exp_nack));
      if (v.rw) check($sformatf("v%0d_rx_data_hold", vi), 32'(rx_data), (n == 2) ? 32'(v.rd1) : 32'(v.rd0));
    end

    // Reset in the middle of a write byte aborts without a STOP
    cfg_rw = 1'b0; cfg_addr_ack = 1'b1; cfg_n = 1; cfg_nack_byte = 15;
    start_txn(1'b0, 7'h04, 3'd1, 8'hE6);
    cycles = 0;
    while (state != 4'd4 && cycles < 500) begin
      @(negedge clk);
      cycles++;
    end
    check("abort_reached_wr_byte", 32'(state), 32'd4);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("abort_scl", 32'(scl), 32'd1);
    check("abort_sda_oe", 32'(sda_oe), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_state", 32'(state), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    repeat (2) @(negedge clk);

    // Start pulses while busy must not launch a second transaction
    cfg_n = 0;
    dn0 = done_cnt;
    start_txn(1'b0, 7'h04, 3'd0, 8'h00);
    repeat (10) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (40) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (200) @(negedge clk);
    check("busy_start_done_count", 32'(done_cnt - dn0), 32'd1);
    check("busy_start_idle", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
